// File: rtl/regfile_sb.sv
// 32x32 register file with a per-register 2-bit pending-write scoreboard and decode stall.
// Optional macro REG_BYPASS_EN forwards the write-back port to the read ports in the same cycle.
module regfile_sb (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_srcA,
  input  logic [4:0]  d_srcB,
  input  logic        d_valid,
  input  logic [4:0]  d_dst,
  input  logic        d_dst_en,
  input  logic        w_en,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] rd_dataA,
  output logic [31:0] rd_dataB,
  output logic        stall,
  output logic        sb_err
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 2;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [CW-1:0] cnt_q  [NREG];
  logic [CW-1:0] cnt_d  [NREG];
  logic          sb_err_q;
  logic          sb_err_d;

  logic          w_hit_c;
  logic          busy_a_c;
  logic          busy_b_c;
  logic          sat_c;
  logic          stall_c;
  logic          issue_c;
  logic          retire_c;
  logic [DW-1:0] rd_a_c;
  logic [DW-1:0] rd_b_c;

  // Read ports, busy terms and decode stall.
  always_comb begin
    w_hit_c  = w_en & (w_addr != '0);
    busy_a_c = (d_srcA != '0) & (cnt_q[d_srcA] != '0);
    busy_b_c = (d_srcB != '0) & (cnt_q[d_srcB] != '0);
    rd_a_c   = (d_srcA == '0) ? '0 : regs_q[d_srcA];
    rd_b_c   = (d_srcB == '0) ? '0 : regs_q[d_srcB];
`ifdef REG_BYPASS_EN
    // A last outstanding write landing this cycle is forwarded, so it no longer blocks.
    if (w_hit_c && (w_addr == d_srcA)) begin
      rd_a_c = w_data;
      if (cnt_q[d_srcA] == CW'(1)) busy_a_c = 1'b0;
    end
    if (w_hit_c && (w_addr == d_srcB)) begin
      rd_b_c = w_data;
      if (cnt_q[d_srcB] == CW'(1)) busy_b_c = 1'b0;
    end
`endif
    sat_c   = d_dst_en & (d_dst != '0) & (cnt_q[d_dst] == '1);
    stall_c = ~reset & d_valid & (busy_a_c | busy_b_c | sat_c);
    if (reset) begin
      rd_a_c = '0;
      rd_b_c = '0;
    end
  end

  // Next-state for array, scoreboard counters and sticky underflow flag.
  always_comb begin
    issue_c  = d_valid & ~stall_c & d_dst_en & (d_dst != '0);
    retire_c = w_hit_c & (cnt_q[w_addr] != '0);
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q | (w_hit_c & (cnt_q[w_addr] == '0));
    if (w_hit_c) regs_d[w_addr] = w_data;
    for (int unsigned i = 0; i < NREG; i++) begin
      if ((issue_c && (d_dst == AW'(i))) && !(retire_c && (w_addr == AW'(i)))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if ((retire_c && (w_addr == AW'(i))) && !(issue_c && (d_dst == AW'(i)))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign rd_dataA = rd_a_c;
  assign rd_dataB = rd_b_c;
  assign stall    = stall_c;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow the REG_BYPASS_EN setting.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  d_srcA;
  logic [4:0]  d_srcB;
  logic        d_valid;
  logic [4:0]  d_dst;
  logic        d_dst_en;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] rd_dataA;
  logic [31:0] rd_dataB;
  logic        stall;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_valid(d_valid),
    .d_dst(d_dst), .d_dst_en(d_dst_en), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .rd_dataA(rd_dataA), .rd_dataB(rd_dataB), .stall(stall), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] dst, input logic dst_en);
    d_valid = v; d_srcA = a; d_srcB = b; d_dst = dst; d_dst_en = dst_en;
  endtask

  task automatic wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    w_en = en; w_addr = addr; w_data = data;
  endtask

  initial begin
    reset = 1'b1;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b0, 5'd0, 32'h0);
    tick(); tick();
    dec(1'b1, 5'd4, 5'd6, 5'd0, 1'b0);
    #1;
    chk("reset_rdA", rd_dataA, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    tick();
    reset = 1'b0;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("post_reset_sb_err", {31'b0, sb_err}, 32'h0);

    // r5 pending, then written; read back next cycle
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    chk("issue5_stall", {31'b0, stall}, 32'h0);
    tick();
    dec(1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd5, 32'h1234);
    #1;
`ifdef REG_BYPASS_EN
    chk("r5_same_cycle", rd_dataA, 32'h1234);
`else
    chk("r5_same_cycle", rd_dataA, 32'h0);
`endif
    tick();
    wr(1'b0, 5'd0, 32'h0);
    dec(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    chk("r5_next_cycle", rd_dataA, 32'h1234);
    chk("r5_not_busy", {31'b0, stall}, 32'h0);
    chk("r5_no_err", {31'b0, sb_err}, 32'h0);
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("r0_reads_zero", rd_dataA, 32'h0);

    // RAW hazard on r9 held until retire
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    chk("issue9_stall", {31'b0, stall}, 32'h0);
    tick();
    dec(1'b1, 5'd0, 5'd9, 5'd0, 1'b0);
    #1;
    chk("r9_busy_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("r9_busy_stall_held", {31'b0, stall}, 32'h1);
    dec(1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    #1;
    chk("no_valid_no_stall", {31'b0, stall}, 32'h0);
    dec(1'b1, 5'd0, 5'd9, 5'd0, 1'b0);
    wr(1'b1, 5'd9, 32'hDEAD);
    #1;
`ifdef REG_BYPASS_EN
    chk("r9_retire_stall", {31'b0, stall}, 32'h0);
    chk("r9_retire_rdB", rd_dataB, 32'hDEAD);
`else
    chk("r9_retire_stall", {31'b0, stall}, 32'h1);
`endif
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("r9_after_stall", {31'b0, stall}, 32'h0);
    chk("r9_after_rdB", rd_dataB, 32'hDEAD);

    // Saturate r3, then simultaneous issue+retire
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r3_issue_stall", {31'b0, stall}, 32'h0);
      tick();
    end
    #1;
    chk("r3_sat_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("r3_sat_held", {31'b0, stall}, 32'h1);
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd3, 32'h33);
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    chk("r3_cnt2_no_stall", {31'b0, stall}, 32'h0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("r3_issue_retire_unchanged", {31'b0, stall}, 32'h0);
    tick();
    chk("r3_resat_stall", {31'b0, stall}, 32'h1);
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd3, 32'h34);
    tick(); tick(); tick();
    wr(1'b0, 5'd0, 32'h0);
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    chk("r3_drained_err", {31'b0, sb_err}, 32'h0);
    chk("r3_drained_stall", {31'b0, stall}, 32'h0);
    chk("r3_value", rd_dataA, 32'h34);

    // Underflow write on r7
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd7, 32'h77);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    chk("r7_sb_err_set", {31'b0, sb_err}, 32'h1);
    chk("r7_written", rd_dataA, 32'h77);
    tick(); tick();
    chk("r7_sb_err_sticky", {31'b0, sb_err}, 32'h1);

    // Reset with r12 pending discards the counter
    dec(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
    tick();
    reset = 1'b1;
    dec(1'b1, 5'd7, 5'd12, 5'd0, 1'b0);
    #1;
    chk("reset_pending_stall", {31'b0, stall}, 32'h0);
    chk("reset_rdA_forced", rd_dataA, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("reset_clears_err", {31'b0, sb_err}, 32'h0);
    chk("reset_clears_cnt", {31'b0, stall}, 32'h0);
    chk("reset_clears_r7", rd_dataA, 32'h0);
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd12, 32'hC);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    chk("discarded_retire_err", {31'b0, sb_err}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset2_clears_err", {31'b0, sb_err}, 32'h0);

    // Writes to r0 are ignored
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("w0_rdA_same", rd_dataA, 32'h0);
    chk("w0_stall", {31'b0, stall}, 32'h0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("w0_rdA_next", rd_dataA, 32'h0);
    chk("w0_sb_err", {31'b0, sb_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have the port clk, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-002 SHALL have the port reset, input, 1 bit, a synchronous active-high reset.
REQ-003 SHALL have the port d_srcA, input, 5 bits, the decode-stage source register A index.
REQ-004 SHALL have the port d_srcB, input, 5 bits, the decode-stage source register B index, driven by the srcB selector.
REQ-005 SHALL have the port d_valid, input, 1 bit, meaning an instruction is present in decode.
REQ-006 SHALL have the port d_dst, input, 5 bits, the destination index of the decoding instruction.
REQ-007 SHALL have the port d_dst_en, input, 1 bit, meaning the decoding instruction writes d_dst.
REQ-008 SHALL have the ports w_en (input, 1 bit), w_addr (input, 5 bits) and w_data (input, 32 bits), forming the write-back port.
REQ-009 SHALL have the ports rd_dataA and rd_dataB, output, 32 bits each, carrying the combinational read data for d_srcA and d_srcB.
REQ-010 SHALL have the port stall, output, 1 bit, a combinational request to hold decode.
REQ-011 SHALL have the port sb_err, output, 1 bit, a sticky scoreboard underflow flag.

Function
REQ-012 SHALL hold 32 registers of 32 bits each; register 0 SHALL read 0 and ignore writes.
REQ-013 SHALL write w_data to reg[w_addr] on the rising clock edge when w_en=1 and w_addr!=0.
REQ-014 SHALL keep a 2-bit pending counter cnt[i] per register, where cnt[0] is always 0.
REQ-015 SHALL define issue = d_valid & !stall & d_dst_en & (d_dst!=0).
REQ-016 SHALL define retire = w_en & (w_addr!=0) & (cnt[w_addr]!=0).
REQ-017 SHALL, at each edge, increment cnt on issue, decrement it on retire, and leave it unchanged when issue and retire hit the same register.
REQ-018 SHALL define busy(r) = (cnt[r]!=0) for r!=0; busy(0) SHALL be 0.
REQ-019 SHALL assert stall = d_valid & (busy(d_srcA) | busy(d_srcB) | (d_dst_en & d_dst!=0 & cnt[d_dst]==3)).
REQ-020 SHALL force stall=0 when d_valid=0.
REQ-021 SHALL, when w_en=1 and w_addr!=0 and cnt[w_addr]==0, still perform the write, hold the counter at 0 and set sb_err=1 until reset.
REQ-022 SHALL never let a counter wrap: the saturation term of the stall (cnt[d_dst]==3) blocks a fourth issue to the same register.
REQ-023 SHALL have no read latency: rd_dataA and rd_dataB are combinational from the array, plus bypass when enabled.

Reset
REQ-024 SHALL, on the edge where reset=1, clear every register, every cnt and sb_err to 0; this takes priority over simultaneous issue or write.
REQ-025 SHALL, while reset=1, drive rd_dataA=rd_dataB=0 and stall=0 at the outputs.
REQ-026 SHALL, when reset hits while counters are pending, discard them; later retires to those registers then assert sb_err.

Configuration
REQ-027 SHALL be controlled by the macro REG_BYPASS_EN.
REQ-028 SHALL, when REG_BYPASS_EN is defined and w_en=1 with w_addr==d_srcX!=0, drive rd_dataX=w_data in the same cycle.
REQ-029 SHALL, when REG_BYPASS_EN is defined and a read source matches a retiring register with cnt==1, exclude that source from busy.
REQ-030 SHALL, when REG_BYPASS_EN is undefined, drive read data from the array only (a write is visible the cycle after) and compute busy purely from cnt.

Verification
REQ-031 SHALL cover: reset; write r5=0x1234 with cnt[5]=1 pending; d_srcA=5 -> rd_dataA=0x1234 on the next cycle; d_srcA=0 -> 0.
REQ-032 SHALL cover: issue d_dst=9, then next cycle d_srcB=9 with d_valid=1 -> stall=1 until retire of r9; then stall=0.
REQ-033 SHALL cover, with REG_BYPASS_EN: cnt[9]=1, w_en=1 w_addr=9 w_data=0xDEAD and d_srcB=9 in the same cycle -> stall=0 and rd_dataB=0xDEAD; without REG_BYPASS_EN -> stall=1 that cycle and stall=0 with rd_dataB=0xDEAD next cycle.
REQ-034 SHALL cover: three issues to r3 -> cnt[3]=3; a fourth with d_dst=3 -> stall=1 and cnt stays 3; simultaneous issue and retire on r3 -> cnt unchanged.
REQ-035 SHALL cover: w_en=1 w_addr=7 with cnt[7]=0 -> reg[7] written and sb_err=1 held; reset -> sb_err=0.
REQ-036 SHALL cover: write w_addr=0 w_data=0xFFFFFFFF -> rd_dataA with d_srcA=0 stays 0, no stall and sb_err unchanged.
